h_bdy_pix_src: RTL
==================

# h_bdy_pix_src

Frame source for the boundary engine: accepts a binary image as packed 32-bit words from the host-side stream and serialises it into one pixel per beat with start-of-frame, end-of-line and end-of-frame markers. It is the producer end of the pixel stream that the boundary engine consumes. Frame geometry is configurable per frame. Rows are word-aligned in the input: each row starts in a fresh word.

## Interface
- W_W, 12: width of the column counter and `cfg_w`; maximum width is 2^W_W-1.
- H_W, 12: width of the row counter and `cfg_h`; maximum height is 2^H_W-1.
- `clk` in 1: the single clock of the block.
- `arst_n` in 1: reset, asynchronous and active-low.
- `cfg_start` in 1: single-cycle request to begin a frame.
- `cfg_w` in W_W: frame width in pixels, sampled on an accepted start.
- `cfg_h` in H_W: frame height in rows, sampled on an accepted start.
- `busy` out 1: a frame is in progress.
- `cfg_err` out 1: one-cycle pulse when a start is rejected because `cfg_w` or `cfg_h` is 0.
- `in_vld` in 1: input word valid.
- `in_dat` in 32: packed pixels; bit 0 is the leftmost pixel.
- `in_rdy` out 1: block accepts an input word.
- `out_vld` out 1: output pixel valid.
- `out_pix` out 1: pixel value.
- `out_sof` out 1: first pixel of the frame (row 0, column 0).
- `out_eol` out 1: last pixel of a row.
- `out_eof` out 1: last pixel of the frame; always coincides with `out_eol`.
- `out_rdy` in 1: downstream accepts the pixel.

## Operation
- The FSM has three states: IDLE, FETCH, EMIT.
- **IDLE**
  - If `cfg_start`=1 and both dims are nonzero: latch `cfg_w`/`cfg_h`, clear `col`, `row` and `bit`, and go to FETCH.
  - If `cfg_start`=1 and either dim is 0: pulse `cfg_err` and stay in IDLE.
- **FETCH**
  - `in_rdy`=1 (decoded directly from the state).
  - On `in_vld & in_rdy`: register the word, set `bit`=0, go to EMIT.
- **EMIT**
  - `out_vld`=1; `out_pix`=word[`bit`].
  - Markers: `out_sof` = (row==0 & col==0); `out_eol` = (col==w-1); `out_eof` = `out_eol` & (row==h-1).
- **Advance in EMIT**, on `out_vld & out_rdy`:
  - If `out_eof`: go to IDLE.
  - Else if `out_eol`: `col`=0, `row`++, go to FETCH. The remaining bits of the word are discarded (row padding).
  - Else if `bit`==31: `col`++, go to FETCH.
  - Else: `bit`++, `col`++, stay in EMIT.
- `busy` = (state != IDLE).
- `cfg_start` outside IDLE is ignored: no error, and latched dims are unchanged.
- Words per row = ceil(w/32). Total words per frame = h × ceil(w/32). Extra input words are not consumed after EOF.
- `col`, `row` and `bit` never wrap: terminal conditions are detected on equality with w-1, h-1 and 31.
- Output payload (`out_pix` and the markers) stays stable while `out_vld`=1 and `out_rdy`=0.

## Timing
- Reset values: state=IDLE, `busy`=0, `cfg_err`=0, `in_rdy`=0, `out_vld`=0, `out_pix`=0, `out_sof`=0, `out_eol`=0, `out_eof`=0.
- An accepted start in cycle t gives `busy`=1 and `in_rdy`=1 in cycle t+1.
- A rejected start in cycle t gives `cfg_err`=1 in cycle t+1 only.
- An input accept in cycle t gives `out_vld`=1 in cycle t+1 with bit 0 of the word.
- Steady state with `out_rdy`=1: one pixel per cycle within a word, then one FETCH cycle per word boundary or row end.
- Minimum frame time for a single-word frame: 1 (FETCH) + w cycles.
- The last pixel accepted in cycle t gives `busy`=0 in cycle t+1. A new start is accepted in cycle t+1 at the earliest.
- Asserting `arst_n`=0 mid-frame forces all outputs to their reset values immediately. The partially emitted frame is abandoned; there is no recovery or flush.

## Test plan
- **3×2 frame:** start with w=3, h=2; words 0x5, 0x2; `out_rdy`=1 -> pixels 1,0,1,0,1,0. `sof` on beat 0, `eol` on beats 2 and 5, `eof` on beat 5. `busy` drops the cycle after beat 5. 2 words consumed.
- **40×1 frame:** words 0xFFFF_FFFF, 0x0000_00AA -> 32 ones, then 0,1,0,1,0,1,0,1. Exactly one FETCH bubble after beat 31. `eof` on beat 39.
- **Backpressure:** 8×1 frame, `out_rdy` toggled 1,0,0,1… -> every payload is held across stalls, no pixel is lost or duplicated, and the order matches the input bits.
- **Bad config:** start with w=0, h=5 -> `cfg_err` pulse of exactly 1 cycle, `busy` stays 0, `in_rdy` stays 0. Then start with w=1, h=1 during an active 16×4 frame -> ignored, and the frame completes with 4 `eol` and 1 `eof`.
- **Reset mid-frame:** drop `arst_n` after 10 pixels of a 32×4 frame -> all outputs are 0 immediately. After release, a new 2×1 frame with word 0x3 emits 1,1 with `sof` on beat 0 and `eol`/`eof` on beat 1.

Source files
------------

// File: rtl/h_bdy_pix_src.sv
// Frame source for the boundary engine: unpacks 32-bit words into a one-pixel-per-beat
// stream with start-of-frame, end-of-line and end-of-frame markers.
module h_bdy_pix_src #(
  parameter int W_W = 12,
  parameter int H_W = 12
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           cfg_start,
  input  logic [W_W-1:0] cfg_w,
  input  logic [H_W-1:0] cfg_h,
  output logic           busy,
  output logic           cfg_err,
  input  logic           in_vld,
  input  logic [31:0]    in_dat,
  output logic           in_rdy,
  output logic           out_vld,
  output logic           out_pix,
  output logic           out_sof,
  output logic           out_eol,
  output logic           out_eof,
  input  logic           out_rdy
);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;

  state_t         state, state_nxt;
  logic [W_W-1:0] w_q, col;
  logic [H_W-1:0] h_q, row;
  logic [4:0]     bit_idx;
  logic [31:0]    word_q;
  logic           cfg_err_q;

  logic start_ok, start_bad, in_fire, out_fire;
  logic at_eol, at_eof, at_sof, last_bit;

  assign start_ok  = (state == IDLE) & cfg_start & (cfg_w != '0) & (cfg_h != '0);
  assign start_bad = (state == IDLE) & cfg_start & ((cfg_w == '0) | (cfg_h == '0));
  assign at_sof    = (row == '0) & (col == '0);
  assign at_eol    = (col == w_q - 1'b1);
  assign at_eof    = at_eol & (row == h_q - 1'b1);
  assign last_bit  = &bit_idx;
  assign in_fire   = (state == FETCH) & in_vld;
  assign out_fire  = (state == EMIT) & out_rdy;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = FETCH;
      FETCH:   if (in_vld) state_nxt = EMIT;
      EMIT: begin
        if (out_rdy) begin
          if (at_eof)                 state_nxt = IDLE;
          else if (at_eol || last_bit) state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    in_rdy  = (state == FETCH);
    out_vld = (state == EMIT);
    out_pix = (state == EMIT) & word_q[bit_idx];
    out_sof = (state == EMIT) & at_sof;
    out_eol = (state == EMIT) & at_eol;
    out_eof = (state == EMIT) & at_eof;
    cfg_err = cfg_err_q;
  end

  // Position counters; bit_idx is rewound on every fetch, so a row end
  // simply abandons the padding bits left in the current word.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      w_q       <= '0;
      h_q       <= '0;
      col       <= '0;
      row       <= '0;
      bit_idx   <= '0;
      word_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= start_bad;
      if (start_ok) begin
        w_q     <= cfg_w;
        h_q     <= cfg_h;
        col     <= '0;
        row     <= '0;
        bit_idx <= '0;
      end
      if (in_fire) begin
        word_q  <= in_dat;
        bit_idx <= '0;
      end
      if (out_fire && !at_eof) begin
        if (at_eol) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
          if (!last_bit) bit_idx <= bit_idx + 1'b1;
        end
      end
    end
  end

endmodule
